// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - K-slice skew feeder in front of the systolic PE array
//
// Accepts one A column / B row slice per cycle and delays lane i by i+1
// cycles, so the operands reach the PE grid as a diagonal wavefront. Cycles
// without an accepted slice inject zero bubbles. After the last slice of a
// job the feeder flushes for FLUSH_CYCLES cycles and pulses done_o.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   a_vec_i, b_vec_i    input slices, lane i = bits [i*DATA_W +: DATA_W]
//   valid_i, last_i     slice valid, final slice of the job
//   ready_o             slice accepted when valid_i && ready_o
//   a_o, b_o            skewed lanes to array rows / columns
//   busy_o              job in progress (STREAM or FLUSH)
//   done_o              one-cycle pulse when the job has fully drained
//   bubble_cnt_o        (FEEDER_BUBBLE_CNT_EN only) bubbles inserted while streaming
//
// Optional feature macro: FEEDER_BUBBLE_CNT_EN

module systolic_feeder #(
  parameter int SYS_ARRAY_SIZE = 4,
  parameter int DATA_W         = 8,
  parameter int FLUSH_CYCLES   = 2 * SYS_ARRAY_SIZE
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [SYS_ARRAY_SIZE*DATA_W-1:0] a_vec_i,
  input  logic [SYS_ARRAY_SIZE*DATA_W-1:0] b_vec_i,
  input  logic                             valid_i,
  input  logic                             last_i,
  output logic                             ready_o,
  output logic [SYS_ARRAY_SIZE*DATA_W-1:0] a_o,
  output logic [SYS_ARRAY_SIZE*DATA_W-1:0] b_o,
  output logic                             busy_o,
  output logic                             done_o
`ifdef FEEDER_BUBBLE_CNT_EN
  ,
  output logic [15:0]                      bubble_cnt_o
`endif
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES);

  // The flush must outlast the deepest lane so lane N-1 drains before done_o.
  if (FLUSH_CYCLES < SYS_ARRAY_SIZE + 1) begin : g_flush_check
    $error("systolic_feeder: FLUSH_CYCLES must be >= SYS_ARRAY_SIZE+1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_FLUSH
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             hs;

  assign ready_o = (state != S_FLUSH);
  assign busy_o  = (state != S_IDLE);
  assign hs      = valid_i && ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done_o     = 1'b0;
    case (state)
      S_IDLE: begin
        if (hs) begin
          if (last_i) begin
            state_next = S_FLUSH;
            cnt_next   = CNT_W'(FLUSH_CYCLES - 1);
          end else begin
            state_next = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        if (hs && last_i) begin
          state_next = S_FLUSH;
          cnt_next   = CNT_W'(FLUSH_CYCLES - 1);
        end
      end
      S_FLUSH: begin
        if (cnt == '0) begin
          done_o     = 1'b1;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Lane i: input register plus i shift stages. Unaccepted cycles load zeros,
  // which travel with the same skew as real data so a/b bubbles stay paired.
  for (genvar i = 0; i < SYS_ARRAY_SIZE; i++) begin : g_lane
    logic [DATA_W-1:0] a_sr [0:i];
    logic [DATA_W-1:0] b_sr [0:i];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int j = 0; j <= i; j++) begin
          a_sr[j] <= '0;
          b_sr[j] <= '0;
        end
      end else begin
        a_sr[0] <= hs ? a_vec_i[i*DATA_W +: DATA_W] : '0;
        b_sr[0] <= hs ? b_vec_i[i*DATA_W +: DATA_W] : '0;
        for (int j = 1; j <= i; j++) begin
          a_sr[j] <= a_sr[j-1];
          b_sr[j] <= b_sr[j-1];
        end
      end
    end

    assign a_o[i*DATA_W +: DATA_W] = a_sr[i];
    assign b_o[i*DATA_W +: DATA_W] = b_sr[i];
  end

`ifdef FEEDER_BUBBLE_CNT_EN
  // Counts streaming cycles starved of input; restarts with each new job.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bubble_cnt_o <= '0;
    end else if (state == S_IDLE && hs) begin
      bubble_cnt_o <= '0;
    end else if (state == S_STREAM && !hs && bubble_cnt_o != 16'hFFFF) begin
      bubble_cnt_o <= bubble_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - directed self-checking bench for systolic_feeder

module tb_systolic_feeder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] a_vec_i;
  logic [31:0] b_vec_i;
  logic        valid_i;
  logic        last_i;
  logic        ready_o;
  logic [31:0] a_o;
  logic [31:0] b_o;
  logic        busy_o;
  logic        done_o;
`ifdef FEEDER_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  systolic_feeder #(
    .SYS_ARRAY_SIZE(4),
    .DATA_W        (8),
    .FLUSH_CYCLES  (8)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .a_vec_i(a_vec_i),
    .b_vec_i(b_vec_i),
    .valid_i(valid_i),
    .last_i (last_i),
    .ready_o(ready_o),
    .a_o    (a_o),
    .b_o    (b_o),
    .busy_o (busy_o),
    .done_o (done_o)
`ifdef FEEDER_BUBBLE_CNT_EN
    ,
    .bubble_cnt_o(bubble_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Hand-computed skewed outputs, index = cycle relative to the first slice.
  localparam logic [31:0] T2_A [0:9] = '{32'h0, 32'h00000001, 32'h00000200, 32'h00030000,
                                          32'h04000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
  localparam logic [31:0] T2_B [0:9] = '{32'h0, 32'h00000005, 32'h00000600, 32'h00070000,
                                          32'h08000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
  localparam logic [31:0] T4_A [0:10] = '{32'h0, 32'h000000A0, 32'h0000A100, 32'h00A200B0,
                                           32'hA300B100, 32'h00B20000, 32'hB3000000,
                                           32'h0, 32'h0, 32'h0, 32'h0};
  localparam logic [31:0] T4_B [0:10] = '{32'h0, 32'h000000C0, 32'h0000C100, 32'h00C200D0,
                                           32'hC300D100, 32'h00D20000, 32'hD3000000,
                                           32'h0, 32'h0, 32'h0, 32'h0};
  localparam logic [31:0] T5_A [0:4] = '{32'h0, 32'h00000001, 32'h00000100, 32'h00010000,
                                          32'h01000000};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic l, input logic [31:0] a, input logic [31:0] b);
    valid_i = v;
    last_i  = l;
    a_vec_i = a;
    b_vec_i = b;
  endtask

  initial begin
    rst_i = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk_i);

    // Test 1: reset state and idle, with a stray last_i that must be ignored.
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, (c == 2), 32'h0, 32'h0);
      check($sformatf("t1 a_o c%0d", c), a_o, 32'h0);
      check($sformatf("t1 b_o c%0d", c), b_o, 32'h0);
      check($sformatf("t1 ready c%0d", c), {31'h0, ready_o}, 32'h1);
      check($sformatf("t1 busy c%0d", c), {31'h0, busy_o}, 32'h0);
      check($sformatf("t1 done c%0d", c), {31'h0, done_o}, 32'h0);
      @(negedge clk_i);
    end

    // Test 2: single-slice job.
    for (int c = 0; c < 10; c++) begin
      if (c == 0) drive(1'b1, 1'b1, 32'h04030201, 32'h08070605);
      else        drive(1'b0, 1'b0, 32'h0, 32'h0);
      check($sformatf("t2 a_o c%0d", c), a_o, T2_A[c]);
      check($sformatf("t2 b_o c%0d", c), b_o, T2_B[c]);
      check($sformatf("t2 done c%0d", c), {31'h0, done_o}, {31'h0, (c == 8)});
      @(negedge clk_i);
    end

    // Test 3: four back-to-back slices, last on the fourth.
    for (int c = 0; c < 12; c++) begin
      if (c < 4) drive(1'b1, (c == 3), {8'(20 + c), 8'h0, 8'h0, 8'(10 + c)},
                       {24'h0, 8'(30 + c)});
      else       drive(1'b0, 1'b0, 32'h0, 32'h0);
      if (c >= 1 && c <= 4) begin
        check($sformatf("t3 a lane0 c%0d", c), {24'h0, a_o[7:0]}, 32'(10 + c - 1));
        check($sformatf("t3 b lane0 c%0d", c), {24'h0, b_o[7:0]}, 32'(30 + c - 1));
      end
      if (c >= 4 && c <= 7)
        check($sformatf("t3 a lane3 c%0d", c), {24'h0, a_o[31:24]}, 32'(20 + c - 4));
      check($sformatf("t3 ready c%0d", c), {31'h0, ready_o}, {31'h0, (c < 4)});
      check($sformatf("t3 done c%0d", c), {31'h0, done_o}, {31'h0, (c == 11)});
      @(negedge clk_i);
    end

    // Test 4: starts the cycle right after done_o; bubble at cycle 1.
    for (int c = 0; c < 11; c++) begin
      if (c == 0) begin
        check("t4 busy after done", {31'h0, busy_o}, 32'h0);
        check("t4 ready after done", {31'h0, ready_o}, 32'h1);
      end
      if (c == 0)      drive(1'b1, 1'b0, 32'hA3A2A1A0, 32'hC3C2C1C0);
      else if (c == 2) drive(1'b1, 1'b1, 32'hB3B2B1B0, 32'hD3D2D1D0);
      else             drive(1'b0, 1'b0, 32'h0, 32'h0);
      check($sformatf("t4 a_o c%0d", c), a_o, T4_A[c]);
      check($sformatf("t4 b_o c%0d", c), b_o, T4_B[c]);
      check($sformatf("t4 done c%0d", c), {31'h0, done_o}, {31'h0, (c == 10)});
      @(negedge clk_i);
    end
`ifdef FEEDER_BUBBLE_CNT_EN
    check("t4 bubble_cnt", {16'h0, bubble_cnt_o}, 32'h1);
`endif

    // Test 5: valid_i held high with 0x55 during FLUSH must not be accepted.
    for (int c = 0; c < 13; c++) begin
      if (c == 0)     drive(1'b1, 1'b1, 32'h01010101, 32'h02020202);
      else if (c < 9) drive(1'b1, 1'b0, 32'h55555555, 32'h55555555);
      else            drive(1'b0, 1'b0, 32'h0, 32'h0);
      if (c <= 4) begin
        check($sformatf("t5 a_o c%0d", c), a_o, T5_A[c]);
        check($sformatf("t5 b_o c%0d", c), b_o, T5_A[c] << 1);
      end else begin
        check($sformatf("t5 a_o c%0d", c), a_o, 32'h0);
        check($sformatf("t5 b_o c%0d", c), b_o, 32'h0);
      end
      if (c >= 1 && c <= 8)
        check($sformatf("t5 ready c%0d", c), {31'h0, ready_o}, 32'h0);
      check($sformatf("t5 done c%0d", c), {31'h0, done_o}, {31'h0, (c == 8)});
      @(negedge clk_i);
    end

    // Test 6: reset during FLUSH aborts the job with no done_o.
    for (int c = 0; c < 14; c++) begin
      rst_i = (c == 5);
      if (c < 4) drive(1'b1, (c == 3), {8'(8'h40 + c), 8'(8'h30 + c), 8'(8'h20 + c), 8'(8'h10 + c)},
                       {8'(8'h40 + c), 8'(8'h30 + c), 8'(8'h20 + c), 8'(8'h10 + c)});
      else       drive(1'b0, 1'b0, 32'h0, 32'h0);
      if (c == 5) begin
        check("t6 a_o before rst", a_o, 32'h41322300);
        check("t6 busy before rst", {31'h0, busy_o}, 32'h1);
      end
      if (c == 6) begin
        check("t6 busy after rst", {31'h0, busy_o}, 32'h0);
        check("t6 ready after rst", {31'h0, ready_o}, 32'h1);
      end
      if (c >= 6) begin
        check($sformatf("t6 a_o c%0d", c), a_o, 32'h0);
        check($sformatf("t6 b_o c%0d", c), b_o, 32'h0);
        check($sformatf("t6 done c%0d", c), {31'h0, done_o}, 32'h0);
      end
      @(negedge clk_i);
    end
    rst_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Upstream stage of the systolic array. Accepts one K-slice per cycle: a column of A and a row of B, each SYS_ARRAY_SIZE elements wide.
- Skews lane i by i cycles so the row/column operands arrive at the PE grid as a diagonal wavefront. The skewed buses drive the array's a/b inputs directly.
- Tracks the job's last slice, flushes the pipeline with zeros, and pulses done_o when the final products have been accumulated. The drain sequencer can then start.

Parameters:
- SYS_ARRAY_SIZE, 4, number of lanes (array rows = columns = N).
- DATA_W, 8, width of one matrix element; equals matrix_data_t width.
- FLUSH_CYCLES, 2*SYS_ARRAY_SIZE, cycles from last-slice handshake to done_o. Legal range >= SYS_ARRAY_SIZE+1; enforce with an elaboration-time assertion.

Ports:
- clk_i, in, 1, clock; all logic on the rising edge.
- rst_i, in, 1, reset; synchronous, active-high.
- a_vec_i, in, N*DATA_W, A column slice; lane i = bits [i*DATA_W +: DATA_W].
- b_vec_i, in, N*DATA_W, B row slice; same lane layout as a_vec_i.
- valid_i, in, 1, slice valid.
- last_i, in, 1, qualifies the final slice of a job; only meaningful with valid_i.
- ready_o, out, 1, feeder accepts a slice this cycle.
- a_o, out, N*DATA_W, skewed A lanes to the array rows.
- b_o, out, N*DATA_W, skewed B lanes to the array columns.
- busy_o, out, 1, high in STREAM or FLUSH.
- done_o, out, 1, single-cycle pulse marking job completion.

Behaviour:
- Clock and reset: single clock clk_i; synchronous active-high reset rst_i.
- Reset values: state=IDLE; all delay registers 0; a_o=b_o=0; busy_o=0; done_o=0; flush counter 0. ready_o=1 after reset.
- Handshake: a slice is accepted when valid_i && ready_o. ready_o is combinational from state: 1 in IDLE and STREAM, 0 in FLUSH.
- Skew datapath:
  - Each lane has one input register, plus i further shift stages for lane i.
  - Lane i of a_o/b_o equals lane i of the accepted input delayed by exactly i+1 cycles. Lane 0 latency is 1.
  - All shift stages advance every cycle regardless of state; there is no stall.
- Bubbles:
  - In any cycle without a handshake, zeros are loaded into every lane's input register.
  - The zeros propagate with the same skew, so a and b bubbles stay aligned and contribute 0 to every PE accumulator.
- State machine:
  - IDLE: on handshake with last_i=0 -> STREAM. On handshake with last_i=1 (single-slice job) -> FLUSH with counter=FLUSH_CYCLES-1. Otherwise stay in IDLE.
  - STREAM: on handshake with last_i=1 -> FLUSH with counter=FLUSH_CYCLES-1. Handshake with last_i=0 or no handshake -> stay in STREAM.
  - FLUSH: counter decrements each cycle. When counter==0: done_o=1 for that cycle and next state=IDLE. valid_i is ignored (ready_o=0).
- done_o timing: if the last slice handshakes in cycle T, done_o is high in cycle T+FLUSH_CYCLES only. busy_o is low in that same cycle's successor.
- Boundary conditions:
  - last_i without valid_i is ignored.
  - Back-to-back jobs: a new slice may be accepted in the cycle immediately after done_o, since state is IDLE then.
  - Lane N-1 output always drains before done_o, because FLUSH_CYCLES >= N+1.
  - rst_i asserted mid-STREAM or mid-FLUSH: next cycle all registers and outputs are 0, state is IDLE, and no done_o is issued for the aborted job.

Optional Feature:
- Macro: FEEDER_BUBBLE_CNT_EN.
- Defined: extra output port bubble_cnt_o, 16 bits.
  - Increments in every STREAM cycle without a handshake; saturates at 0xFFFF.
  - Cleared on reset and on the cycle a job starts (IDLE handshake).
  - Holds its value after done_o until the next job starts.
- Undefined: the port and counter are absent; the remaining behaviour is identical.

Test Plan (N=4, DATA_W=8, FLUSH_CYCLES=8):
- Reset, then idle for 5 cycles -> a_o=b_o=0, ready_o=1, busy_o=0, done_o never high.
- Slice a_vec={4,3,2,1} (lane0=1), b_vec={8,7,6,5} accepted at cycle 0 with last_i=1 -> output lanes: a_o lane0=1 at cycle 1, lane1=2 at cycle 2, lane2=3 at cycle 3, lane3=4 at cycle 4; b lanes 5..8 at the same cycles; all other lane cycles 0; done_o only at cycle 8.
- 4 consecutive slices with lane0 values 10,11,12,13 at cycles 0-3, last_i on the 4th -> a_o lane0 shows 10..13 at cycles 1-4; ready_o=0 at cycles 4-11; done_o at cycle 11; busy_o=0 at cycle 12.
- Slices at cycles 0 and 2 (valid_i low at cycle 1) -> zero lane values in both a_o and b_o at each lane's skewed position of cycle 1; with FEEDER_BUBBLE_CNT_EN, bubble_cnt_o=1.
- valid_i held high during FLUSH with value 0x55 -> no acceptance; 0x55 never appears on a_o/b_o.
- rst_i pulsed at cycle 5 of FLUSH -> next cycle state IDLE, outputs 0, no done_o pulse.
